// File: rtl/pll_lock_qualifier_if.sv
// Signal bundle between the PLL lock qualifier and its surrounding logic.
// The slave side is the qualifier itself; the master side drives the raw flag and run request.
interface pll_lock_qualifier_if #(
   parameter int LOSS_CNT_W = 8
) ();
   logic                  pll_locked_raw;
   logic                  run_req;
   logic                  pll_locked;
   logic                  clk_en;
   logic                  pll_areset;
   logic [LOSS_CNT_W-1:0] loss_count;
   logic [1:0]            fsm_state;

   modport master (
      output pll_locked_raw,
      output run_req,
      input  pll_locked,
      input  clk_en,
      input  pll_areset,
      input  loss_count,
      input  fsm_state
   );

   modport slave (
      input  pll_locked_raw,
      input  run_req,
      output pll_locked,
      output clk_en,
      output pll_areset,
      output loss_count,
      output fsm_state
   );
endinterface

// File: rtl/pll_lock_qualifier.sv
// Qualifies the asynchronous PLL lock flag into a clean pll_locked / clk_en pair,
// counts lock losses and pulses pll_areset when lock never arrives.
module pll_lock_qualifier #(
   parameter int SYNC_STAGES    = 2,
   parameter int LOCK_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int PLL_RST_CYCLES = 16,
   parameter int ENABLE_DELAY   = 8,
   parameter int LOSS_CNT_W     = 8
) (
   input  logic                 clk_in,
   input  logic                 reset,
   pll_lock_qualifier_if.slave  bus
);

   localparam int MAX_A  = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_B  = (PLL_RST_CYCLES > ENABLE_DELAY) ? PLL_RST_CYCLES : ENABLE_DELAY;
   localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] ENABLE_LAST  = CNT_W'(ENABLE_DELAY - 1);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_QUAL = 2'd1,
      S_LOCK = 2'd2,
      S_PRST = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lk_s;
   logic                   pll_locked;
   logic                   clk_en;
   logic                   pll_areset;
   logic [LOSS_CNT_W-1:0]  loss_count;

   function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Synchronizer: bit 0 samples the asynchronous flag, the top bit feeds the FSM.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.pll_locked_raw};
      end
   end

   assign lk_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state      <= S_WAIT;
         cnt        <= '0;
         pll_locked <= 1'b0;
         clk_en     <= 1'b0;
         pll_areset <= 1'b0;
         loss_count <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (lk_s) begin
                  state <= S_QUAL;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state      <= S_PRST;
                  cnt        <= '0;
                  pll_areset <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_QUAL: begin
               if (!lk_s) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end else if (cnt == LOCK_LAST) begin
                  state      <= S_LOCK;
                  cnt        <= '0;
                  pll_locked <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_LOCK: begin
               // Lock loss outranks run_req so clk_en can never outlive pll_locked.
               if (!lk_s) begin
                  state      <= S_WAIT;
                  cnt        <= '0;
                  pll_locked <= 1'b0;
                  clk_en     <= 1'b0;
                  loss_count <= sat_inc(loss_count);
               end else if (!bus.run_req) begin
                  clk_en <= 1'b0;
                  cnt    <= '0;
               end else if (!clk_en) begin
                  if (cnt == ENABLE_LAST) begin
                     clk_en <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_PRST: begin
               if (cnt == PRST_LAST) begin
                  state      <= S_WAIT;
                  cnt        <= '0;
                  pll_areset <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.pll_locked = pll_locked;
   assign bus.clk_en     = clk_en;
   assign bus.pll_areset = pll_areset;
   assign bus.loss_count = loss_count;
   assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pll_lock_qualifier.sv
// Directed bench for pll_lock_qualifier using small parameters and hand-derived edge counts.
// Edge 1 is the first rising clock edge after reset is released.
module tb_pll_lock_qualifier;

   logic clk_in;
   logic reset;
   int   checks;
   int   passed;

   pll_lock_qualifier_if #(.LOSS_CNT_W(2)) bus ();

   pll_lock_qualifier #(
      .SYNC_STAGES   (2),
      .LOCK_CYCLES   (8),
      .TIMEOUT_CYCLES(32),
      .PLL_RST_CYCLES(4),
      .ENABLE_DELAY  (3),
      .LOSS_CNT_W    (2)
   ) dut (
      .clk_in(clk_in),
      .reset (reset),
      .bus   (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic do_reset(input logic raw_val, input logic run_val);
      reset              = 1'b1;
      bus.pll_locked_raw = 1'b0;
      bus.run_req        = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      reset              = 1'b0;
      bus.pll_locked_raw = raw_val;
      bus.run_req        = run_val;
   endtask

   task automatic test_reset;
      do_reset(1'b0, 1'b0);
      reset = 1'b1;
      wait_edges(2);
      checks++;
      if ({bus.pll_locked, bus.clk_en, bus.pll_areset, bus.loss_count, bus.fsm_state} !== 7'd0)
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {bus.pll_locked, bus.clk_en, bus.pll_areset, bus.loss_count, bus.fsm_state});
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_clean_lock;
      do_reset(1'b1, 1'b1);
      wait_edges(3);
      checks++;
      if (bus.fsm_state !== 2'd1) $display("FAIL lock_qual_e3: got %0d expected 1", bus.fsm_state);
      else passed++;
      wait_edges(7);
      checks++;
      if (bus.pll_locked !== 1'b0) $display("FAIL lock_e10: got %0b expected 0", bus.pll_locked);
      else passed++;
      wait_edges(1);
      checks++;
      if (bus.pll_locked !== 1'b1) $display("FAIL lock_e11: got %0b expected 1", bus.pll_locked);
      else passed++;
      checks++;
      if (bus.fsm_state !== 2'd2) $display("FAIL lock_state_e11: got %0d expected 2", bus.fsm_state);
      else passed++;
      wait_edges(2);
      checks++;
      if (bus.clk_en !== 1'b0) $display("FAIL clk_en_e13: got %0b expected 0", bus.clk_en);
      else passed++;
      wait_edges(1);
      checks++;
      if (bus.clk_en !== 1'b1) $display("FAIL clk_en_e14: got %0b expected 1", bus.clk_en);
      else passed++;
      checks++;
      if (bus.loss_count !== 2'd0) $display("FAIL lock_loss_cnt: got %0d expected 0", bus.loss_count);
      else passed++;
   endtask

   task automatic test_glitch;
      do_reset(1'b1, 1'b0);
      wait_edges(3);
      checks++;
      if (bus.fsm_state !== 2'd1) $display("FAIL glitch_qual: got %0d expected 1", bus.fsm_state);
      else passed++;
      wait_edges(2);
      bus.pll_locked_raw = 1'b0;
      wait_edges(2);
      checks++;
      if (bus.fsm_state !== 2'd1) $display("FAIL glitch_still_qual_e7: got %0d expected 1", bus.fsm_state);
      else passed++;
      wait_edges(1);
      checks++;
      if (bus.fsm_state !== 2'd0) $display("FAIL glitch_wait_e8: got %0d expected 0", bus.fsm_state);
      else passed++;
      wait_edges(10);
      checks++;
      if ({bus.pll_locked, bus.loss_count} !== 3'b000)
         $display("FAIL glitch_no_lock: got %b expected 000", {bus.pll_locked, bus.loss_count});
      else passed++;
   endtask

   task automatic test_timeout;
      do_reset(1'b0, 1'b0);
      wait_edges(31);
      checks++;
      if ({bus.pll_areset, bus.fsm_state} !== 3'b000)
         $display("FAIL timeout_e31: got %b expected 000", {bus.pll_areset, bus.fsm_state});
      else passed++;
      wait_edges(1);
      checks++;
      if ({bus.pll_areset, bus.fsm_state} !== 3'b111)
         $display("FAIL timeout_e32: got %b expected 111", {bus.pll_areset, bus.fsm_state});
      else passed++;
      wait_edges(3);
      checks++;
      if (bus.pll_areset !== 1'b1) $display("FAIL areset_e35: got %0b expected 1", bus.pll_areset);
      else passed++;
      wait_edges(1);
      checks++;
      if ({bus.pll_areset, bus.fsm_state} !== 3'b000)
         $display("FAIL areset_e36: got %b expected 000", {bus.pll_areset, bus.fsm_state});
      else passed++;
      wait_edges(31);
      checks++;
      if (bus.fsm_state !== 2'd0) $display("FAIL timeout2_e67: got %0d expected 0", bus.fsm_state);
      else passed++;
      wait_edges(1);
      checks++;
      if ({bus.pll_areset, bus.fsm_state} !== 3'b111)
         $display("FAIL timeout2_e68: got %b expected 111", {bus.pll_areset, bus.fsm_state});
      else passed++;
   endtask

   task automatic test_loss;
      logic [1:0] exp_loss;
      do_reset(1'b1, 1'b1);
      wait_edges(14);
      bus.pll_locked_raw = 1'b0;
      wait_edges(2);
      checks++;
      if ({bus.pll_locked, bus.clk_en} !== 2'b11)
         $display("FAIL loss_e2: got %b expected 11", {bus.pll_locked, bus.clk_en});
      else passed++;
      wait_edges(1);
      checks++;
      if ({bus.pll_locked, bus.clk_en, bus.loss_count, bus.fsm_state} !== 6'b000100)
         $display("FAIL loss_e3: got %b expected 000100",
                  {bus.pll_locked, bus.clk_en, bus.loss_count, bus.fsm_state});
      else passed++;
      for (int i = 0; i < 3; i++) begin
         exp_loss = (i == 0) ? 2'd2 : 2'd3;
         bus.pll_locked_raw = 1'b1;
         wait_edges(11);
         checks++;
         if (bus.pll_locked !== 1'b1) $display("FAIL relock_%0d: got %0b expected 1", i, bus.pll_locked);
         else passed++;
         bus.pll_locked_raw = 1'b0;
         wait_edges(3);
         checks++;
         if ({bus.pll_locked, bus.loss_count} !== {1'b0, exp_loss})
            $display("FAIL loss_cnt_%0d: got %b expected %b", i,
                     {bus.pll_locked, bus.loss_count}, {1'b0, exp_loss});
         else passed++;
      end
   endtask

   task automatic test_run_req;
      do_reset(1'b1, 1'b1);
      wait_edges(14);
      checks++;
      if (bus.clk_en !== 1'b1) $display("FAIL run_en_start: got %0b expected 1", bus.clk_en);
      else passed++;
      bus.run_req = 1'b0;
      wait_edges(1);
      checks++;
      if ({bus.pll_locked, bus.clk_en} !== 2'b10)
         $display("FAIL run_drop: got %b expected 10", {bus.pll_locked, bus.clk_en});
      else passed++;
      wait_edges(2);
      bus.run_req = 1'b1;
      wait_edges(2);
      checks++;
      if (bus.clk_en !== 1'b0) $display("FAIL run_reassert_e2: got %0b expected 0", bus.clk_en);
      else passed++;
      wait_edges(1);
      checks++;
      if ({bus.pll_locked, bus.clk_en} !== 2'b11)
         $display("FAIL run_reassert_e3: got %b expected 11", {bus.pll_locked, bus.clk_en});
      else passed++;
   endtask

   task automatic test_async_reset;
      do_reset(1'b1, 1'b1);
      wait_edges(5);
      checks++;
      if (bus.fsm_state !== 2'd1) $display("FAIL async_pre_qual: got %0d expected 1", bus.fsm_state);
      else passed++;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus.pll_locked, bus.clk_en, bus.pll_areset, bus.fsm_state} !== 5'd0)
         $display("FAIL async_qual: got %b expected 00000",
                  {bus.pll_locked, bus.clk_en, bus.pll_areset, bus.fsm_state});
      else passed++;
      do_reset(1'b0, 1'b0);
      wait_edges(33);
      checks++;
      if ({bus.pll_areset, bus.fsm_state} !== 3'b111)
         $display("FAIL async_pre_prst: got %b expected 111", {bus.pll_areset, bus.fsm_state});
      else passed++;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus.pll_locked, bus.clk_en, bus.pll_areset, bus.fsm_state} !== 5'd0)
         $display("FAIL async_prst: got %b expected 00000",
                  {bus.pll_locked, bus.clk_en, bus.pll_areset, bus.fsm_state});
      else passed++;
      do_reset(1'b1, 1'b1);
      wait_edges(11);
      checks++;
      if ({bus.pll_locked, bus.fsm_state} !== 3'b110)
         $display("FAIL async_resume_lock: got %b expected 110", {bus.pll_locked, bus.fsm_state});
      else passed++;
      wait_edges(3);
      checks++;
      if (bus.clk_en !== 1'b1) $display("FAIL async_resume_en: got %0b expected 1", bus.clk_en);
      else passed++;
   endtask

   initial begin
      checks             = 0;
      passed             = 0;
      reset              = 1'b1;
      bus.pll_locked_raw = 1'b0;
      bus.run_req        = 1'b0;
      test_reset();
      test_clean_lock();
      test_glitch();
      test_timeout();
      test_loss();
      test_run_req();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
